// File: rtl/elevator.sv
// Elevator car: tracks floor, models per-floor travel time and interlocks the door.
// Define ELEVATOR_DOOR_HOLD_EN to keep the door open at least DOOR_HOLD cycles.
module elevator #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_TICKS = 20,
  parameter int DOOR_HOLD   = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       door_open,
  input  logic [1:0] updown,
  output logic       door,
  output logic [2:0] floor,
  output logic       moving
);

  // state     | meaning
  // IDLE      | parked at a floor, door closed
  // MOVE_UP   | travelling one floor up
  // MOVE_DOWN | travelling one floor down
  // DOOR_OPEN | parked with door open, motion commands ignored
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  localparam int            CW       = $clog2(FLOOR_TICKS);
  localparam logic [2:0]    TOP      = 3'(NUM_FLOORS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FLOOR_TICKS - 1);

  if (NUM_FLOORS < 2 || NUM_FLOORS > 8 || FLOOR_TICKS < 2 || DOOR_HOLD < 1) begin : g_bad_param
    $error("elevator: parameter out of range");
  end

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_floor;
  logic          r_door;
  logic          r_moving;

  logic       w_up_cmd;
  logic       w_dn_cmd;
  logic       w_arrive;
  logic [2:0] w_floor_nxt;
  logic       w_hold_done;
  logic       w_door_nxt;
  logic       w_moving_nxt;

  assign w_up_cmd = (updown == 2'b01);
  assign w_dn_cmd = (updown == 2'b10);
  assign w_arrive = ((r_state == MOVE_UP) || (r_state == MOVE_DOWN)) && (r_cnt == CNT_LAST);

  always_comb begin
    w_floor_nxt = r_floor;
    if (w_arrive && (r_state == MOVE_UP))   w_floor_nxt = r_floor + 3'd1;
    if (w_arrive && (r_state == MOVE_DOWN)) w_floor_nxt = r_floor - 3'd1;
  end

`ifdef ELEVATOR_DOOR_HOLD_EN
  localparam int HW = $clog2(DOOR_HOLD + 1);
  logic [HW-1:0] r_hold;

  // Reload on entry so every open cycle gets the full minimum time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if ((w_next == DOOR_OPEN) && (r_state != DOOR_OPEN)) begin
      r_hold <= HW'(DOOR_HOLD);
    end else if ((r_state == DOOR_OPEN) && (r_hold != '0)) begin
      r_hold <= r_hold - 1'b1;
    end
  end

  assign w_hold_done = (r_hold == '0);
`else
  assign w_hold_done = 1'b1;
`endif

  // State register plus the registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_floor  <= 3'd0;
      r_door   <= 1'b0;
      r_moving <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_floor  <= w_floor_nxt;
      r_door   <= w_door_nxt;
      r_moving <= w_moving_nxt;
      if (w_moving_nxt && !w_arrive && (r_state != IDLE)) r_cnt <= r_cnt + 1'b1;
      else                                                 r_cnt <= '0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (door_open)                         w_next = DOOR_OPEN;
        else if (w_up_cmd && (r_floor < TOP))  w_next = MOVE_UP;
        else if (w_dn_cmd && (r_floor != 3'd0)) w_next = MOVE_DOWN;
      end
      MOVE_UP: begin
        if (w_arrive) begin
          if (door_open)                             w_next = DOOR_OPEN;
          else if (w_up_cmd && (w_floor_nxt != TOP)) w_next = MOVE_UP;
          else                                       w_next = IDLE;
        end
      end
      MOVE_DOWN: begin
        if (w_arrive) begin
          if (door_open)                              w_next = DOOR_OPEN;
          else if (w_dn_cmd && (w_floor_nxt != 3'd0)) w_next = MOVE_DOWN;
          else                                        w_next = IDLE;
        end
      end
      DOOR_OPEN: begin
        if (!door_open && w_hold_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_door_nxt   = (w_next == DOOR_OPEN);
    w_moving_nxt = (w_next == MOVE_UP) || (w_next == MOVE_DOWN);
  end

  assign door   = r_door;
  assign floor  = r_floor;
  assign moving = r_moving;

endmodule

// File: tb/tb_elevator.sv
// Scoreboard bench for the elevator car: stimulus queues expected outputs, a monitor checks them.
module tb_elevator;

  logic       clk;
  logic       rst_n;
  logic       door_open;
  logic [1:0] updown;
  logic       door;
  logic [2:0] floor;
  logic       moving;

  elevator #(.NUM_FLOORS(8), .FLOOR_TICKS(4), .DOOR_HOLD(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .door_open (door_open),
    .updown    (updown),
    .door      (door),
    .floor     (floor),
    .moving    (moving)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef ELEVATOR_DOOR_HOLD_EN
  int hold_steps = 5;
`else
  int hold_steps = 0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got door=%0b floor=%0d moving=%0b, want door=%0b floor=%0d moving=%0b",
               nm, act[4], act[3:1], act[0], exp[4], exp[3:1], exp[0]);
    end
  endtask

  // Drive inputs for the next edge and record what the outputs must be after it.
  task automatic step(input logic d_o, input logic [1:0] ud, input logic e_door,
                      input logic [2:0] e_floor, input logic e_mov, input string nm);
    exp_t e;
    @(negedge clk);
    door_open = d_o;
    updown    = ud;
    e.cyc  = cyc + 1;
    e.exp  = {e_door, e_floor, e_mov};
    e.name = nm;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s: expectation for cycle %0d not sampled, now cycle %0d", e.name, e.cyc, cyc);
        end else begin
          check(e.name, {door, floor, moving}, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got time %0t, want below 200000", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t e;
    door_open = 1'b0;
    updown    = 2'b00;
    rst_n     = 1'b0;
    #1 check("reset_init", {door, floor, moving}, 5'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step(0, 2'b00, 0, 3'd0, 0, "idle_stop");
    step(0, 2'b10, 0, 3'd0, 0, "down_at_0");
    step(0, 2'b10, 0, 3'd0, 0, "down_at_0");

    // single floor up with a one-cycle command
    step(0, 2'b01, 0, 3'd0, 1, "up_start");
    repeat (3) step(0, 2'b00, 0, 3'd0, 1, "up_travel");
    step(0, 2'b00, 0, 3'd1, 0, "up_arrive");

    // continuous travel 1 -> 7, then top limit
    step(0, 2'b01, 0, 3'd1, 1, "cont_start");
    for (int f = 2; f <= 7; f++) begin
      repeat (3) step(0, 2'b01, 0, 3'(f - 1), 1, "cont_travel");
      step(0, 2'b01, 0, 3'(f), (f != 7), "cont_arrive");
    end
    repeat (3) step(0, 2'b01, 0, 3'd7, 0, "top_limit");

    // continuous travel 7 -> 2, stop command on the final arrival
    step(0, 2'b10, 0, 3'd7, 1, "dn_start");
    for (int f = 6; f >= 2; f--) begin
      repeat (3) step(0, 2'b10, 0, 3'(f + 1), 1, "dn_travel");
      step(0, (f == 2) ? 2'b00 : 2'b10, 0, 3'(f), (f != 2), "dn_arrive");
    end

    // door request wins over an up command; held long enough to outlast any hold time
    step(1, 2'b01, 1, 3'd2, 0, "door_prio");
    repeat (6) step(1, 2'b01, 1, 3'd2, 0, "door_held");
    step(0, 2'b01, 0, 3'd2, 0, "door_close");
    step(0, 2'b01, 0, 3'd2, 1, "start_after_close");

    // door request mid-travel takes effect at arrival
    repeat (3) step(1, 2'b00, 0, 3'd2, 1, "midtravel");
    step(1, 2'b00, 1, 3'd3, 0, "arrive_door");
    for (int i = 0; i < hold_steps; i++) step(0, 2'b00, 1, 3'd3, 0, "door_hold");
    step(0, 2'b00, 0, 3'd3, 0, "door_closed");

    // one-cycle door pulse from IDLE
    step(1, 2'b00, 1, 3'd3, 0, "pulse_open");
    for (int i = 0; i < hold_steps; i++) step(0, 2'b00, 1, 3'd3, 0, "pulse_hold");
    step(0, 2'b00, 0, 3'd3, 0, "pulse_close");

    repeat (2) step(0, 2'b11, 0, 3'd3, 0, "stop_11");

    // asynchronous reset while moving up from floor 3
    step(0, 2'b01, 0, 3'd3, 1, "pre_reset_move");
    step(0, 2'b01, 0, 3'd3, 1, "pre_reset_move");
    @(negedge clk);
    updown = 2'b00;
    #1 rst_n = 1'b0;
    #1 check("async_reset", {door, floor, moving}, 5'b0);
    @(posedge clk);
    #1 check("reset_hold", {door, floor, moving}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 2'b00, 0, 3'd0, 0, "post_reset");
    step(0, 2'b01, 0, 3'd0, 1, "post_reset_move");

    repeat (2) @(negedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never checked, now cycle %0d", e.name, e.cyc, cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator.md
Name: elevator

Overview:
- Car model for the elevator subsystem. A floor controller drives it with a door-open request and a 2-bit up/down command.
- Reports the current floor and the door state back to that controller.
- Models travel time per floor and refuses to move while the door is open.
- Floors run from 0 to NUM_FLOORS-1.

Parameters:
- NUM_FLOORS, 8: number of floors, legal range 2..8; top floor is NUM_FLOORS-1.
- FLOOR_TICKS, 20: clk cycles to travel one floor; must be at least 2. At 100 ms per cycle this is 2 s.
- DOOR_HOLD, 25: minimum cycles the door stays open. Used only when ELEVATOR_DOOR_HOLD_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- door_open  in  1  level request: 1 = open/keep the door open, 0 = close it.
- updown  in  2  motion command: 2'b01 = up, 2'b10 = down, 2'b00 or 2'b11 = stop.
- door  out  1  registered; 1 = door open.
- floor  out  3  registered current floor, 0..NUM_FLOORS-1.
- moving  out  1  registered; 1 while in MOVE_UP or MOVE_DOWN.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, floor=0, door=0, moving=0, travel counter=0. All outputs are held at these values while rst_n=0.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE, evaluated each edge, first match wins:
  - door_open=1 -> DOOR_OPEN; door=1 on that edge. The door request has priority over motion.
  - updown=01 and floor<NUM_FLOORS-1 -> MOVE_UP; counter=0, moving=1.
  - updown=10 and floor>0 -> MOVE_DOWN; counter=0, moving=1.
  - Otherwise stay in IDLE.
  - At the limits, an up command at the top floor or a down command at floor 0 is ignored silently.
- MOVE_UP / MOVE_DOWN:
  - counter increments every cycle.
  - On the edge where counter==FLOOR_TICKS-1, floor steps by ±1. Floor therefore changes exactly FLOOR_TICKS edges after the move started.
  - Continue: at that arrival edge, if updown still commands the same direction, the new floor is not a limit, and door_open=0, stay in the move state with counter=0. Continuous travel gives one floor every FLOOR_TICKS cycles.
  - Otherwise go to IDLE with moving=0, or straight to DOOR_OPEN with door=1 if door_open=1.
- A move in progress always completes. Changing updown or asserting door_open mid-travel takes effect only at arrival; there is no reversal mid-floor.
- DOOR_OPEN:
  - door=1; updown is ignored.
  - door_open=0 -> IDLE with door=0 on the next edge.
  - The bench treats a door rising edge as "stopped at a floor" and a falling edge as "ready to move". Each open/close cycle therefore produces exactly one door pulse.
- floor never leaves 0..NUM_FLOORS-1.
- updown=11 behaves exactly like stop.
- door and moving are never 1 at the same time.

Optional Feature:
- ELEVATOR_DOOR_HOLD_EN defined:
  - On entering DOOR_OPEN, a hold counter loads DOOR_HOLD.
  - The door stays open until the counter reaches 0, even if door_open drops earlier.
  - It then closes on the first edge with door_open=0.
- ELEVATOR_DOOR_HOLD_EN not defined: the door closes on the edge after door_open=0, with no minimum open time.

Test Plan (FLOOR_TICKS=4, NUM_FLOORS=8 unless noted):
- Reset mid-operation: assert rst_n=0 while in MOVE_UP at floor 3 -> floor=0, door=0, moving=0 immediately (asynchronously), before any clk edge.
- Single floor up: updown=01 from floor 0 for 1 cycle, then 00 -> moving=1 next edge; floor=1 exactly 4 edges after the start; moving=0 at that edge.
- Continuous travel and limit: updown=01 held from floor 0 -> floor increments every 4 cycles up to 7, then moving=0. Further up commands leave floor=7. updown=10 at floor 0 -> no movement.
- Door interlock: at floor 2, door_open=1 together with updown=01 -> door=1, floor stays 2, moving=0. Drop door_open -> door=0 next edge, then the move starts.
- Mid-travel door request: door_open=1 asserted 1 cycle after starting 2->3 -> floor reaches 3 on schedule, then door=1 on the same arrival edge; no continuation.
- Door hold (ELEVATOR_DOOR_HOLD_EN, DOOR_HOLD=5): door_open pulsed for 1 cycle -> door high for at least 5 cycles. Without the macro -> door high for 1 cycle.
